// File: rtl/receiver.sv
// UART 8N1 receiver: synchronised line, mid-bit sampling,
// start-glitch rejection and framing-error pulse.
module receiver #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       Rx_in,
  output logic       Rx_DV_out,
  output logic [7:0] Rx_Byte_out,
  output logic       Rx_Active_out,
  output logic       Rx_Err_out
);

  localparam logic [7:0] H    = 8'((CLKS_PER_BIT - 1) / 2);
  localparam logic [7:0] LAST = 8'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    CLEANUP
  } state_e;

  logic       s1_q, s2_q, s3_q;
  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] data_q, data_d;
  logic [7:0] byte_q, byte_d;
  logic       dv_q, dv_d;
  logic       err_q, err_d;
  logic       act_q, act_d;

  logic rx_sync;
  logic start_edge;

  assign rx_sync    = s2_q;
  assign start_edge = s3_q & ~s2_q;

  // Two-stage synchroniser plus a delayed copy for falling-edge detect
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
      s3_q <= 1'b1;
    end else begin
      s1_q <= Rx_in;
      s2_q <= s1_q;
      s3_q <= s2_q;
    end
  end

  // FSM and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      idx_q   <= 3'd0;
      data_q  <= 8'd0;
      byte_q  <= 8'd0;
      dv_q    <= 1'b0;
      err_q   <= 1'b0;
      act_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      byte_q  <= byte_d;
      dv_q    <= dv_d;
      err_q   <= err_d;
      act_q   <= act_d;
    end
  end

  // Next-state: half-bit start check, then one sample per bit period
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    byte_d  = byte_q;
    dv_d    = dv_q;
    err_d   = err_q;
    act_d   = act_q;
    case (state_q)
      IDLE: begin
        cnt_d = 8'd0;
        idx_d = 3'd0;
        if (start_edge) begin
          state_d = START;
          act_d   = 1'b1;
        end
      end
      START: begin
        if (cnt_q == H) begin
          cnt_d = 8'd0;
          if (!rx_sync) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
            act_d   = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DATA: begin
        if (cnt_q == LAST) begin
          cnt_d         = 8'd0;
          data_d[idx_q] = rx_sync;
          if (idx_q < 3'd7) begin
            idx_d = idx_q + 3'd1;
          end else begin
            idx_d   = 3'd0;
            state_d = STOP;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      STOP: begin
        if (cnt_q == LAST) begin
          cnt_d   = 8'd0;
          state_d = CLEANUP;
          if (rx_sync) begin
            byte_d = data_q;
            dv_d   = 1'b1;
          end else begin
            err_d  = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      CLEANUP: begin
        dv_d    = 1'b0;
        err_d   = 1'b0;
        act_d   = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Rx_DV_out     = dv_q;
  assign Rx_Byte_out   = byte_q;
  assign Rx_Active_out = act_q;
  assign Rx_Err_out    = err_q;

endmodule

// File: tb/tb_receiver.sv
// Scoreboard bench for receiver: 217-clk/bit directed frames
// plus a 16-clk/bit loopback instance.
module tb_receiver;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
    longint     when;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rst_n_b = 1'b0;
  logic       rx_a = 1'b1;
  logic       rx_b = 1'b1;
  logic       dv_a, dv_b;
  logic       err_a, err_b;
  logic       act_a, act_b;
  logic [7:0] byte_a, byte_b;

  longint cyc = 0;
  int checks = 0;
  int errors = 0;
  exp_t q0[$];
  exp_t q1[$];
  logic [7:0] last_good[2];
  bit pp[2];
  logic [7:0] pb[2];

  receiver #(.CLKS_PER_BIT(217)) dut_a (
    .CLK(clk), .RST_N(rst_n), .Rx_in(rx_a),
    .Rx_DV_out(dv_a), .Rx_Byte_out(byte_a),
    .Rx_Active_out(act_a), .Rx_Err_out(err_a)
  );

  receiver #(.CLKS_PER_BIT(16)) dut_b (
    .CLK(clk), .RST_N(rst_n_b), .Rx_in(rx_b),
    .Rx_DV_out(dv_b), .Rx_Byte_out(byte_b),
    .Rx_Active_out(act_b), .Rx_Err_out(err_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [7:0] act,
                     input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s got %02h want %02h", nm, act, req);
    end
  endtask

  // Drive one frame; expectation pushed at the start bit
  task automatic send(input int w, input logic [7:0] d,
                      input logic sb, input bit push);
    logic [9:0] fr;
    int cpb;
    exp_t e;
    fr  = {sb, d, 1'b0};
    cpb = (w == 0) ? 217 : 16;
    for (int i = 0; i < 10; i++) begin
      #1;
      if (w == 0) rx_a = fr[i];
      else rx_b = fr[i];
      if (i == 0 && push) begin
        e.err  = ~sb;
        e.data = sb ? d : last_good[w];
        e.when = cyc + 4 + (cpb - 1) / 2 + 9 * cpb;
        if (w == 0) q0.push_back(e);
        else q1.push_back(e);
        if (sb) last_good[w] = d;
      end
      repeat (cpb) @(posedge clk);
    end
  endtask

  task automatic mon(input int w, input logic dv, input logic er,
                     input logic [7:0] b, input logic act,
                     input logic rn);
    exp_t e;
    bit empty;
    if (!rn) begin
      pp[w] = 1'b0;
      pb[w] = b;
      return;
    end
    if (pp[w]) begin
      checks++;
      if (act !== 1'b0 || dv !== 1'b0 || er !== 1'b0) begin
        errors++;
        $display("FAIL pulse_end dut%0d act=%b dv=%b err=%b want 000",
                 w, act, dv, er);
      end
    end
    checks++;
    if (!dv && b !== pb[w]) begin
      errors++;
      $display("FAIL byte_hold dut%0d got %02h want %02h", w, b, pb[w]);
    end
    if (dv || er) begin
      checks++;
      empty = (w == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
        errors++;
        $display("FAIL unexpected dut%0d dv=%b err=%b byte=%02h want none",
                 w, dv, er, b);
      end else begin
        e = (w == 0) ? q0.pop_front() : q1.pop_front();
        if (dv !== ~e.err || er !== e.err || b !== e.data ||
            act !== 1'b1 || cyc != e.when) begin
          errors++;
          $display("FAIL frame dut%0d dv=%b err=%b byte=%02h act=%b cyc=%0d want err=%b byte=%02h act=1 cyc=%0d",
                   w, dv, er, b, act, cyc, e.err, e.data, e.when);
        end
      end
    end
    pp[w] = dv || er;
    pb[w] = b;
  endtask

  always @(negedge clk) begin
    mon(0, dv_a, err_a, byte_a, act_a, rst_n);
    mon(1, dv_b, err_b, byte_b, act_b, rst_n_b);
  end

  initial begin
    logic [9:0] fr;
    last_good[0] = 8'h00;
    last_good[1] = 8'h00;
    repeat (5) @(posedge clk);
    #1;
    chk("rst_dv", {7'd0, dv_a}, 8'h00);
    chk("rst_err", {7'd0, err_a}, 8'h00);
    chk("rst_act", {7'd0, act_a}, 8'h00);
    chk("rst_byte", byte_a, 8'h00);
    rst_n   = 1'b1;
    rst_n_b = 1'b1;
    repeat (10) @(posedge clk);
    fork
      begin
        send(0, 8'h55, 1'b1, 1'b1);
        repeat (300) @(posedge clk);
        fr = {1'b1, 8'hA5, 1'b0};
        for (int i = 0; i < 4; i++) begin
          #1 rx_a = fr[i];
          repeat (217) @(posedge clk);
        end
        #1 rx_a = fr[4];
        repeat (108) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_dv", {7'd0, dv_a}, 8'h00);
        chk("mid_rst_err", {7'd0, err_a}, 8'h00);
        chk("mid_rst_act", {7'd0, act_a}, 8'h00);
        chk("mid_rst_byte", byte_a, 8'h00);
        rx_a = 1'b1;
        last_good[0] = 8'h00;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        send(0, 8'hA5, 1'b1, 1'b1);
        send(0, 8'h00, 1'b1, 1'b1);
        send(0, 8'hFF, 1'b1, 1'b1);
        send(0, 8'h3C, 1'b1, 1'b1);
        repeat (300) @(posedge clk);
        #1 rx_a = 1'b0;
        repeat (20) @(posedge clk);
        #1 chk("glitch_act_hi", {7'd0, act_a}, 8'h01);
        repeat (29) @(posedge clk);
        #1 rx_a = 1'b1;
        repeat (250) @(posedge clk);
        #1 chk("glitch_act_lo", {7'd0, act_a}, 8'h00);
        send(0, 8'h81, 1'b0, 1'b1);
        repeat (30 * 217) @(posedge clk);
        #1 chk("break_act", {7'd0, act_a}, 8'h00);
        rx_a = 1'b1;
        repeat (2 * 217) @(posedge clk);
        send(0, 8'h42, 1'b1, 1'b1);
        #1 rx_a = 1'b1;
      end
      begin
        for (int n = 0; n < 256; n++) begin
          send(1, 8'($urandom), 1'b1, 1'b1);
        end
        #1 rx_b = 1'b1;
      end
    join
    for (int i = 0; i < 5000 && (q0.size() != 0 || q1.size() != 0); i++)
      @(posedge clk);
    repeat (5) @(posedge clk);
    chk("drain_a", 8'(q0.size()), 8'h00);
    chk("drain_b", 8'(q1.size()), 8'h00);
    chk("final_byte_a", byte_a, 8'h42);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/receiver.md
# receiver

UART receiver core: deserialises the asynchronous serial line into 8-bit parallel bytes, in the standard 8N1 format (1 start bit, 8 data bits LSB first, 1 stop bit). It sits opposite `transmitter` on the board UART link and feeds received bytes to the CPU's host/debug interface. Each bit is sampled once, at its mid-point. The serial input is synchronised, the start bit is validated, and framing errors are flagged.

## Interface
- CLKS_PER_BIT, 217, system clocks per bit = f_CLK / baud (25 MHz / 115200). Legal range is 4..255.
- CLK  input  1  system clock; all logic on the rising edge.
- RST_N  input  1  asynchronous, active-low reset.
- Rx_in  input  1  raw serial line (idle = 1); asynchronous to CLK.
- Rx_DV_out  output  1  one-cycle pulse: Rx_Byte_out holds a newly received, correctly framed byte.
- Rx_Byte_out  output  8  last good byte; holds its value until the next good frame.
- Rx_Active_out  output  1  high while a frame is being received.
- Rx_Err_out  output  1  one-cycle pulse: stop bit sampled 0 (framing error).

## Operation
- **Synchroniser:** 2-FF chain Rx_in → s1 → s2 (Rx_sync), plus a third FF s3 for edge detection. All three reset to 1.
- **Start edge:** s3 = 1 and s2 = 0. Edge-triggered, not level-triggered: a line held low (break) never re-arms the receiver.
- **Definitions:** H = (CLKS_PER_BIT−1)/2 (integer division). Clock_Count is 8 bits. Bit_Index is 3 bits. Data shift/hold register is 8 bits.
- **State machine:** 5 states, reset state IDLE.
  - **IDLE:** Clock_Count=0, Bit_Index=0. On start edge → START.
  - **START:** Clock_Count increments until it equals H.
    - At Clock_Count==H, if Rx_sync==0: → DATA with Clock_Count=0.
    - Otherwise the start was a glitch: → IDLE, with no output activity.
  - **DATA:** Clock_Count increments to CLKS_PER_BIT−1.
    - At Clock_Count==CLKS_PER_BIT−1: data[Bit_Index] ← Rx_sync and Clock_Count=0.
    - If Bit_Index<7, increment Bit_Index. Otherwise Bit_Index=0 and → STOP.
  - **STOP:** Clock_Count increments to CLKS_PER_BIT−1, then samples Rx_sync.
    - Sample = 1: Rx_Byte_out ← data, Rx_DV_out ← 1.
    - Sample = 0: Rx_Err_out ← 1; Rx_Byte_out is unchanged.
    - Either way → CLEANUP.
  - **CLEANUP:** one cycle. Rx_DV_out ← 0, Rx_Err_out ← 0, Rx_Active_out ← 0. → IDLE.
  - **Illegal state encodings:** → IDLE.
- **Rx_Active_out:** set on the IDLE→START edge. Cleared on START→IDLE (glitch) or in CLEANUP.
- **Resync:** the receiver returns to IDLE about half a bit before the end of the stop bit. This gives it margin for the next frame's start edge.

## Timing
- **Reset values:** Rx_DV_out=0, Rx_Err_out=0, Rx_Active_out=0, Rx_Byte_out=8'h00. State=IDLE; counters and data register 0; s1/s2/s3=1.
- **Reset mid-frame:** on assertion, all outputs and state return to reset values immediately (asynchronous). The partial byte is discarded. After deassertion the receiver waits for a fresh start edge.
- **Reference instant:** let t0 be the CLK edge at which s1 first captures 0.
  - t0+2: FSM enters START; Rx_Active_out=1 after this edge.
  - Data bit i is sampled at t0+3+H+(i+1)·CLKS_PER_BIT.
  - Stop bit is sampled at t0+3+H+9·CLKS_PER_BIT. Rx_DV_out or Rx_Err_out is high for exactly the following cycle.
  - At default CLKS_PER_BIT=217 (H=108), Rx_DV_out rises after edge t0+2064.
- **Pulse coincidence:** Rx_DV_out and Rx_Err_out are never high in the same cycle.
- **Byte update timing:** Rx_Byte_out changes only on the edge that raises Rx_DV_out.
- **Back-to-back frames:** a start bit immediately after a stop bit is detected, with zero idle time. No bytes are lost.
- **Flow control:** none. The consumer must capture Rx_Byte_out within one frame time.

## Test plan
- **Reset:** assert RST_N=0 mid-frame (during DATA bit 3) → all outputs 0 and Rx_Byte_out=00 immediately. After release, the next frame 0xA5 is received normally.
- **Single byte:** transmit 0x55 at CLKS_PER_BIT=217 → one Rx_DV_out pulse at t0+2064 (±0), Rx_Byte_out=0x55, Rx_Err_out stays 0.
- **Back-to-back:** send 0x00, 0xFF, 0x3C with no idle gap → three DV pulses, 9.5..10 bit times apart, with bytes in order.
- **Glitch rejection:** low pulse on Rx_in of 50 clocks (< H) → Rx_Active_out pulses, then the FSM returns to IDLE; no DV, no Err.
- **Framing error:** frame 0x81 with stop bit forced 0 → Rx_Err_out one-cycle pulse, no DV, Rx_Byte_out keeps its previous value.
- **Break / re-arm:** hold the line low for 30 bit times after the framing error → no further Err or DV pulses. After the line returns high, frame 0x42 is received correctly.
- **Loopback:** loop `transmitter` Tx_out to Rx_in at CLKS_PER_BIT=16 with 256 random bytes → every byte matches, with zero errors.
